// File: rtl/jt51_mixacc_pkg.sv
// Shared constants and helpers for the jt51_mixacc operator mixer:
// carrier masks per connection algorithm, operator indices and saturation.
package jt51_mixacc_pkg;

  localparam logic [1:0] OP_M1 = 2'd0;
  localparam logic [1:0] OP_M2 = 2'd1;
  localparam logic [1:0] OP_C1 = 2'd2;
  localparam logic [1:0] OP_C2 = 2'd3;

  // Bit order {C2,C1,M2,M1}: a set bit means that operator is a carrier.
  localparam logic [3:0] CON_MASK [8] = '{
    4'b1000, 4'b1000, 4'b1000, 4'b1000,
    4'b1100, 4'b1110, 4'b1110, 4'b1111
  };

  function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int ow);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (ow - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (ow - 1));
    if (v > hi) sat = hi;
    else if (v < lo) sat = lo;
    else sat = v;
  endfunction

endpackage

// File: rtl/jt51_mixacc_sat.sv
// Combinational signed saturation from IW to OW bits, flagging when the
// value had to be clamped.
module jt51_mixacc_sat
  import jt51_mixacc_pkg::*;
#(
  parameter int IW = 17,
  parameter int OW = 16
) (
  input  logic signed [IW-1:0] din,
  output logic signed [OW-1:0] dout,
  output logic                 clip
);

  logic signed [31:0] ext;
  logic signed [31:0] res;

  always_comb begin
    ext  = 32'(din);
    res  = sat(ext, OW);
    dout = res[OW-1:0];
    clip = (res != ext);
  end

endmodule

// File: rtl/jt51_mixacc.sv
// Time-multiplexed FM operator mixer: per-channel carrier sums, L/R panning
// and saturation to the output width, one stereo sample per frame.
module jt51_mixacc
  import jt51_mixacc_pkg::*;
#(
  parameter int CH  = 8,
  parameter int OPS = 4,
  parameter int IW  = 14,
  parameter int NW  = 12,
  parameter int OW  = 16,
  parameter int AW  = OW + $clog2(CH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cen,
  input  logic                        zero,
  input  logic [2:0]                  con_I,
  input  logic [1:0]                  rl_I,
  input  logic signed [IW-1:0]        op_out,
  input  logic                        ne,
  input  logic signed [NW-1:0]        noise_mix,
  input  logic [CH-1:0]               ch_mute,
  output logic signed [OW-1:0]        left,
  output logic signed [OW-1:0]        right,
  output logic                        sample,
  output logic                        clip_l,
  output logic                        clip_r,
  output logic [$clog2(CH*OPS)-1:0]   slot
);

  localparam int CW = $clog2(CH);
  localparam int SW = $clog2(CH*OPS);
  localparam logic [SW-1:0] LAST = SW'(CH*OPS-1);

  logic [SW-1:0]        slot_q, slot_d, cur_slot;
  logic [CW-1:0]        ch;
  logic [1:0]           op;
  logic                 synced_q, synced_d;
  logic                 active, frame_end;
  logic signed [IW-1:0] operand_raw, operand;
  logic signed [OW-1:0] buf_q [CH];
  logic signed [OW-1:0] buf_d [CH];
  logic signed [OW:0]   chan_sum;
  logic signed [OW-1:0] chan;
  logic                 unused_chan_clip;
  logic signed [AW-1:0] pre_l_q, pre_l_d, pre_r_q, pre_r_d;
  logic signed [AW-1:0] pre_l_acc, pre_r_acc;
  logic signed [OW-1:0] left_q, left_d, right_q, right_d, left_sat, right_sat;
  logic                 clip_l_q, clip_l_d, clip_r_q, clip_r_d, clip_l_sat, clip_r_sat;
  logic                 sample_q, sample_d;

  // A zero strobe overrides the running count so the slot restarts at ch0/M1.
  always_comb begin
    cur_slot    = zero ? '0 : slot_q;
    ch          = cur_slot[CW-1:0];
    op          = cur_slot[SW-1:CW];
    active      = synced_q | zero;
    frame_end   = (cur_slot == LAST);
    operand_raw = op_out;
    if (ne && op == OP_C2 && ch == CW'(CH-1)) operand_raw = IW'(noise_mix);
    operand = '0;
    if (CON_MASK[con_I][op] && !ch_mute[ch]) operand = operand_raw;
    chan_sum = (OW+1)'(buf_q[ch]) + (OW+1)'(operand);
  end

  jt51_mixacc_sat #(.IW(OW+1), .OW(OW)) u_chan_sat (
    .din  (chan_sum),
    .dout (chan),
    .clip (unused_chan_clip)
  );

  // Channel 0 starts a fresh stereo accumulation, which also discards any partial frame.
  always_comb begin
    pre_l_acc = (ch == '0) ? '0 : pre_l_q;
    pre_r_acc = (ch == '0) ? '0 : pre_r_q;
    if (rl_I[0]) pre_l_acc = pre_l_acc + AW'(chan);
    if (rl_I[1]) pre_r_acc = pre_r_acc + AW'(chan);
  end

  jt51_mixacc_sat #(.IW(AW), .OW(OW)) u_left_sat (
    .din  (pre_l_acc),
    .dout (left_sat),
    .clip (clip_l_sat)
  );

  jt51_mixacc_sat #(.IW(AW), .OW(OW)) u_right_sat (
    .din  (pre_r_acc),
    .dout (right_sat),
    .clip (clip_r_sat)
  );

  always_comb begin
    slot_d   = slot_q;
    synced_d = synced_q;
    buf_d    = buf_q;
    pre_l_d  = pre_l_q;
    pre_r_d  = pre_r_q;
    left_d   = left_q;
    right_d  = right_q;
    clip_l_d = clip_l_q;
    clip_r_d = clip_r_q;
    sample_d = sample_q;
    if (cen) begin
      slot_d   = frame_end ? '0 : cur_slot + SW'(1);
      synced_d = synced_q | zero;
      sample_d = 1'b0;
      if (active) begin
        buf_d[ch] = (op == OP_M1) ? OW'(operand) : chan;
        if (op == OP_C2) begin
          pre_l_d = pre_l_acc;
          pre_r_d = pre_r_acc;
        end
        if (frame_end) begin
          left_d   = left_sat;
          right_d  = right_sat;
          clip_l_d = clip_l_sat;
          clip_r_d = clip_r_sat;
          sample_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q   <= '0;
      synced_q <= 1'b0;
      buf_q    <= '{default: '0};
      pre_l_q  <= '0;
      pre_r_q  <= '0;
      left_q   <= '0;
      right_q  <= '0;
      clip_l_q <= 1'b0;
      clip_r_q <= 1'b0;
      sample_q <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      synced_q <= synced_d;
      buf_q    <= buf_d;
      pre_l_q  <= pre_l_d;
      pre_r_q  <= pre_r_d;
      left_q   <= left_d;
      right_q  <= right_d;
      clip_l_q <= clip_l_d;
      clip_r_q <= clip_r_d;
      sample_q <= sample_d;
    end
  end

  assign left   = left_q;
  assign right  = right_q;
  assign sample = sample_q;
  assign clip_l = clip_l_q;
  assign clip_r = clip_r_q;
  assign slot   = slot_q;

endmodule

// File: tb/tb_jt51_mixacc.sv
// Self-checking bench for jt51_mixacc: frame-level mixing model plus
// hand-computed expectations for each directed frame.
module tb_jt51_mixacc;

  localparam int CH    = 8;
  localparam int NSLOT = 32;

  logic clk = 1'b0;
  logic rst, cen, zero, ne;
  logic [2:0] con_I;
  logic [1:0] rl_I;
  logic signed [13:0] op_out;
  logic signed [11:0] noise_mix;
  logic [7:0] ch_mute;
  logic signed [15:0] left, right;
  logic sample, clip_l, clip_r;
  logic [4:0] slot;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;
  int sample_seen = 0;
  int cnt0;

  int cfg_con [CH];
  int cfg_rl [CH];
  int cfg_op [4];
  logic [7:0] cfg_mute, cfg_mute2;
  int cfg_sw;
  bit cfg_ne;
  int cfg_noise;

  int m_slot, m_cur, m_c, m_o, m_v, m_s, mL, mR;
  bit m_synced, m_act;
  int opnd [CH][4];
  int rl_rec [CH];
  int exp_left, exp_right, exp_cl, exp_cr, exp_sample;

  jt51_mixacc dut (
    .clk(clk), .rst(rst), .cen(cen), .zero(zero), .con_I(con_I), .rl_I(rl_I),
    .op_out(op_out), .ne(ne), .noise_mix(noise_mix), .ch_mute(ch_mute),
    .left(left), .right(right), .sample(sample), .clip_l(clip_l), .clip_r(clip_r),
    .slot(slot)
  );

  always #5 clk = ~clk;

  function automatic int satv(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Carrier operators per algorithm: 0-3 only C2, 4 both C's, 5-6 all but M1, 7 all.
  function automatic bit is_carrier(input int con, input int o);
    if (con <= 3) return o == 3;
    if (con == 4) return o >= 2;
    if (con <= 6) return o >= 1;
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Model: collect every accepted operand of the frame, mix the whole frame at its last slot.
  always @(posedge clk) begin
    if (rst) begin
      m_slot = 0; m_synced = 0;
      exp_left = 0; exp_right = 0; exp_cl = 0; exp_cr = 0; exp_sample = 0;
    end else if (cen) begin
      m_cur = zero ? 0 : m_slot;
      m_act = m_synced || zero;
      if (zero) m_synced = 1;
      exp_sample = 0;
      if (m_act) begin
        m_c = m_cur % CH;
        m_o = m_cur / CH;
        m_v = (ne && m_o == 3 && m_c == CH-1) ? int'(noise_mix) : int'(op_out);
        if (!is_carrier(int'(con_I), m_o) || ch_mute[m_c]) m_v = 0;
        opnd[m_c][m_o] = m_v;
        if (m_o == 3) rl_rec[m_c] = int'(rl_I);
        if (m_cur == NSLOT-1) begin
          mL = 0; mR = 0;
          for (int c = 0; c < CH; c++) begin
            m_s = opnd[c][0];
            for (int o = 1; o < 4; o++) m_s = satv(m_s + opnd[c][o]);
            if ((rl_rec[c] & 1) != 0) mL += m_s;
            if ((rl_rec[c] & 2) != 0) mR += m_s;
          end
          exp_left = satv(mL);
          exp_right = satv(mR);
          exp_cl = int'(mL != exp_left);
          exp_cr = int'(mR != exp_right);
          exp_sample = 1;
        end
      end
      m_slot = (m_cur + 1) % NSLOT;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("left", int'(left), exp_left);
      checkOutput("right", int'(right), exp_right);
      checkOutput("sample", int'(sample), exp_sample);
      checkOutput("clip_l", int'(clip_l), exp_cl);
      checkOutput("clip_r", int'(clip_r), exp_cr);
      checkOutput("slot", int'(slot), m_slot);
      if (sample) sample_seen++;
    end
  end

  task automatic applyStimulus(input int s, input bit z);
    int c, o;
    c = s % CH;
    o = s / CH;
    cen = 1'b1;
    zero = z;
    con_I = 3'(cfg_con[c]);
    rl_I = 2'(cfg_rl[c]);
    op_out = 14'(cfg_op[o]);
    ne = cfg_ne;
    noise_mix = 12'(cfg_noise);
    ch_mute = (s >= cfg_sw) ? cfg_mute2 : cfg_mute;
    @(negedge clk);
  endtask

  task automatic runFrame(input bit z0, input int n, input bit gaps);
    for (int s = 0; s < n; s++) begin
      applyStimulus(s, z0 && s == 0);
      if (gaps && (s % 3 == 1) && s != n-1) begin
        cen = 1'b0;
        zero = 1'b0;
        op_out = 14'($urandom);
        @(negedge clk);
      end
    end
  endtask

  task automatic checkFrame(input string name, input int l, input int r, input int cl, input int cr);
    checkOutput({name, "_left"}, int'(left), l);
    checkOutput({name, "_right"}, int'(right), r);
    checkOutput({name, "_clip_l"}, int'(clip_l), cl);
    checkOutput({name, "_clip_r"}, int'(clip_r), cr);
    checkOutput({name, "_sample"}, int'(sample), 1);
  endtask

  task automatic setCfg(input int con, input int rl, input int o0, input int o1,
                        input int o2, input int o3, input logic [7:0] mute);
    for (int c = 0; c < CH; c++) begin
      cfg_con[c] = con;
      cfg_rl[c] = rl;
    end
    cfg_op[0] = o0; cfg_op[1] = o1; cfg_op[2] = o2; cfg_op[3] = o3;
    cfg_mute = mute;
    cfg_mute2 = mute;
    cfg_sw = 99;
    cfg_ne = 1'b0;
    cfg_noise = 0;
  endtask

  initial begin
    rst = 1'b1; cen = 1'b0; zero = 1'b0; ne = 1'b0; con_I = '0; rl_I = '0;
    op_out = '0; noise_mix = '0; ch_mute = '0;
    setCfg(7, 3, 100, 100, 100, 100, 8'h00);
    repeat (3) @(negedge clk);
    checkOutput("reset_left", int'(left), 0);
    checkOutput("reset_sample", int'(sample), 0);
    checkOutput("reset_slot", int'(slot), 0);
    chk_en = 1;
    rst = 1'b0;

    $display("[TB] unsynced run");
    for (int i = 0; i < 64; i++) applyStimulus(i % NSLOT, 1'b0);
    checkOutput("nosync_pulses", sample_seen, 0);
    checkOutput("nosync_left", int'(left), 0);

    $display("[TB] con7 ch0 only");
    setCfg(7, 3, 100, 100, 100, 100, 8'hFE);
    runFrame(1'b1, NSLOT, 1'b0);
    checkFrame("con7", 400, 400, 0, 0);

    $display("[TB] con0 all channels");
    setCfg(0, 1, 5000, 5000, 5000, 1000, 8'h00);
    runFrame(1'b0, NSLOT, 1'b0);
    checkFrame("con0", 8000, 0, 0, 0);

    $display("[TB] saturation");
    setCfg(7, 3, 8191, 8191, 8191, 8191, 8'h00);
    runFrame(1'b1, NSLOT, 1'b0);
    checkFrame("satpos", 32767, 32767, 1, 1);
    setCfg(7, 3, -8192, -8192, -8192, -8192, 8'h00);
    runFrame(1'b1, NSLOT, 1'b0);
    checkFrame("satneg", -32768, -32768, 1, 1);

    $display("[TB] cen gaps and mid-frame mute");
    setCfg(7, 1, 100, 100, 100, 100, 8'h00);
    cfg_mute2 = 8'h04;
    cfg_sw = 10;
    runFrame(1'b1, NSLOT, 1'b1);
    checkFrame("mute", 2900, 0, 0, 0);
    cen = 1'b0;
    zero = 1'b1;
    repeat (3) @(negedge clk);
    zero = 1'b0;
    checkFrame("hold", 2900, 0, 0, 0);

    $display("[TB] noise");
    setCfg(0, 1, 3000, 3000, 3000, 3000, 8'h7F);
    cfg_ne = 1'b1;
    cfg_noise = -2048;
    runFrame(1'b1, NSLOT, 1'b0);
    checkFrame("noise", -2048, 0, 0, 0);

    $display("[TB] mid-frame zero");
    setCfg(7, 3, 8191, 8191, 8191, 8191, 8'h00);
    runFrame(1'b0, 13, 1'b0);
    setCfg(7, 2, 100, 100, 100, 100, 8'hFC);
    runFrame(1'b1, NSLOT, 1'b0);
    checkFrame("rezero", 0, 800, 0, 0);

    $display("[TB] mid-frame reset");
    setCfg(7, 3, 8191, 8191, 8191, 8191, 8'h00);
    runFrame(1'b0, 20, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_left", int'(left), 0);
    checkOutput("rst_right", int'(right), 0);
    checkOutput("rst_sample", int'(sample), 0);
    checkOutput("rst_slot", int'(slot), 0);
    cnt0 = sample_seen;
    for (int i = 0; i < 40; i++) applyStimulus(i % NSLOT, 1'b0);
    checkOutput("rst_nosync_pulses", sample_seen - cnt0, 0);
    setCfg(4, 3, 1, 2, 300, 400, 8'h00);
    runFrame(1'b1, NSLOT, 1'b0);
    checkFrame("con4", 5600, 5600, 0, 0);

    cen = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jt51_mixacc.md
Name: jt51_mixacc

Overview:
Parametrised successor to the FM operator accumulator. Takes one time-multiplexed operator sample per cen slot, sums carrier operators per channel according to the connection algorithm, pans each channel to L/R, and saturates to the output width. Differences from the current accumulator: parametrised channel/operator counts and widths, per-channel mute, explicit frame sync, a sample strobe and clip flags. Sits between the operator pipeline and the DAC/exp-format stage.

Parameters:
CH, 8, channels per frame (power of 2, 2..16)
OPS, 4, operators per channel (fixed to 4 for the algorithm table; parameter kept for mask width)
IW, 14, operator sample width (signed)
NW, 12, noise sample width (signed, NW<=IW)
OW, 16, output width (signed)
AW, OW+$clog2(CH)+1, stereo pre-accumulator width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cen  in  1  clock enable; one slot per cen cycle
zero  in  1  marks the current slot as slot 0 (ch0, op0); resyncs the counter
con_I  in  3  algorithm of the channel owning the current slot
rl_I  in  2  pan of the current slot's channel: [1]=right enable, [0]=left enable
op_out  in  IW  signed operator output for the current slot
ne  in  1  noise enable
noise_mix  in  NW  signed noise sample
ch_mute  in  CH  per-channel mute, bit n = channel n
left  out  OW  signed saturated left sample
right  out  OW  signed saturated right sample
sample  out  1  one-cen-cycle pulse when left/right update
clip_l  out  1  left saturated on the last update (held with the sample)
clip_r  out  1  right saturated on the last update
slot  out  $clog2(CH*OPS)  current slot index (debug)

Behaviour:
- Clock/reset: one clock clk; reset rst is synchronous and active-high. All state advances only when cen=1.
- Reset: left=right=0, sample=0, clip_l=clip_r=0, slot=0, synced=0, and all accumulators cleared.
- Slot counter: slot = op*CH + ch, with op order M1=0, M2=1, C1=2, C2=3.
  - On cen with zero=1: the current slot is taken as 0.
  - Otherwise slot increments and wraps CH*OPS-1 -> 0.
  - synced sets on the first zero. Before that, nothing accumulates and sample never pulses.
- Input select: if ne=1 and slot is (op=C2, ch=CH-1), the operand is sign-extended noise_mix; otherwise it is op_out.
- Sum enable: mask = CON_MASK[con_I][op]. Operand is zeroed if the mask bit is 0 or ch_mute[ch]=1.
- Per-channel sum: CH-entry OW-wide circular buffer indexed by ch.
  - op=M1: entry loads the operand (replace, not add).
  - Other ops: entry = sat_OW(entry + operand).
- Channel close at op=C2:
  - chan = sat_OW(entry + operand).
  - pre_left += rl_I[0] ? chan : 0; pre_right += rl_I[1] ? chan : 0. Full AW width, no wrap possible.
  - ch=0 at op=C2 loads pre_* instead of adding.
- Frame end (slot CH*OPS-1, registered on the same cen):
  - left = sat_OW(pre_left final), right = sat_OW(pre_right final).
  - clip_* = 1 if saturation occurred, else 0.
  - sample=1 for the following cen cycle only.
- Latency: the last operand enters -> left/right valid on the next clk edge with cen; sample is high during that cen cycle.
- Saturation: positive overflow -> 2^(OW-1)-1; negative -> -2^(OW-1).
- Boundary cases:
  - zero mid-frame: partial frame discarded; the pre_* frame is restarted by the ch0/C2 load; no sample for the truncated frame.
  - ch_mute changing mid-frame takes effect on the next operand.
  - rst mid-frame: returns to the reset state; synced cleared.
  - cen=0: all outputs hold, sample included.

Decomposition:
- Package jt51_mixacc_pkg holds:
  - CON_MASK[8] of 4 bits ({C2,C1,M2,M1}): con0-3=1000, con4=1100, con5-6=1110, con7=1111.
  - op index constants OP_M1..OP_C2.
  - a sat function parameterised by input/output width.
- One sub-module, jt51_mixacc_sat: a combinational saturate-with-clip-flag instance, used for the channel sums and the L/R outputs.

Test Plan:
- Reset/sync: rst, then cen without zero for 64 cycles -> sample never 1, left=right=0; first zero -> sample pulses 32 cen cycles later (CH=8).
- con7 mixing: all ops=100, rl=11, ch0 only unmuted -> left=right=400, clip=0.
- con0 on all 8 channels, C2=1000, others=5000, rl=01 -> left=8000, right=0.
- Saturation: con7, all ops=+8191, all channels rl=11 -> left=right=32767, clip_l=clip_r=1. Same with -8192 -> -32768.
- Noise: ne=1, ch7 con0, noise_mix=-2048, op_out=3000, others muted -> left=-2048.
- Mid-frame zero and rst: zero at slot 13 -> no sample until 32 cycles after it, values from the new frame only; rst at slot 20 -> outputs 0, sample 0 until re-sync.
